// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - Shared opcodes, state encodings and IR field positions for proc_ctrl_fsm (honours PROC_CTRL_ILLEGAL_EN)
package proc_pkg;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;

    // Field positions of the default III XXX YYY instruction layout
    localparam int IR_OPC_MSB = 8;
    localparam int IR_OPC_LSB = 6;
    localparam int IR_RX_MSB  = 5;
    localparam int IR_RX_LSB  = 3;
    localparam int IR_RY_MSB  = 2;
    localparam int IR_RY_LSB  = 0;

`ifdef PROC_CTRL_ILLEGAL_EN
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_T0 = 2'd0,
        ST_T1 = 2'd1,
        ST_T2 = 2'd2,
        ST_T3 = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - Register index to one-hot select decoder with enable
module dec_onehot #(
    parameter int W = 3,
    localparam int N = 2**W
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    // Single bit set at idx when enabled, otherwise all zero
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// rtl/proc_ctrl_fsm.sv - Multicycle T0-T3 control sequencer for the simple processor (optional PROC_CTRL_ILLEGAL_EN adds illegal/HALT)
module proc_ctrl_fsm
    import proc_pkg::*;
#(
    parameter int REG_W = 3,
    parameter int OPC_W = 3,
    parameter int IR_W  = 9,
    localparam int NREG = 2**REG_W
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [IR_W-1:0] ir_q,
    output logic            irin,
    output logic [NREG-1:0] rin,
    output logic [NREG-1:0] rout,
    output logic            ain,
    output logic            gin,
    output logic            gout,
    output logic            dinout,
    output logic            addsub,
    output logic            done
`ifdef PROC_CTRL_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam int OPC_LSB = 2 * REG_W;
    localparam int RX_LSB  = REG_W;
    localparam int RY_LSB  = 0;

    state_t state;
    state_t next_state;

    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] ry;
    logic [REG_W-1:0] rout_idx;
    logic             rin_en;
    logic             rout_en;
    logic             rout_sel_y;

    assign opc      = ir_q[OPC_LSB +: OPC_W];
    assign rx       = ir_q[RX_LSB +: REG_W];
    assign ry       = ir_q[RY_LSB +: REG_W];
    assign rout_idx = rout_sel_y ? ry : rx;

    // State register; clear returns to T0 from anywhere, including mid-instruction
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_T0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; clear overrides every output to 0
    always_comb begin
        next_state = state;
        irin       = 1'b0;
        ain        = 1'b0;
        gin        = 1'b0;
        gout       = 1'b0;
        dinout     = 1'b0;
        addsub     = 1'b0;
        done       = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_sel_y = 1'b0;
`ifdef PROC_CTRL_ILLEGAL_EN
        illegal    = 1'b0;
`endif
        case (state)
            ST_T0: begin
                irin = run;
                if (run) begin
                    next_state = ST_T1;
                end
            end
            ST_T1: begin
                next_state = ST_T0;
                if (opc == OPC_W'(OPC_MV)) begin
                    rout_en    = 1'b1;
                    rout_sel_y = 1'b1;
                    rin_en     = 1'b1;
                    done       = 1'b1;
                end else if (opc == OPC_W'(OPC_MVI)) begin
                    dinout = 1'b1;
                    rin_en = 1'b1;
                    done   = 1'b1;
                end else if (opc == OPC_W'(OPC_ADD) || opc == OPC_W'(OPC_SUB)) begin
                    rout_en    = 1'b1;
                    ain        = 1'b1;
                    next_state = ST_T2;
                end else begin
`ifdef PROC_CTRL_ILLEGAL_EN
                    illegal    = 1'b1;
                    next_state = ST_HALT;
`else
                    done       = 1'b1;
`endif
                end
            end
            ST_T2: begin
                rout_en    = 1'b1;
                rout_sel_y = 1'b1;
                gin        = 1'b1;
                addsub     = (opc == OPC_W'(OPC_SUB));
                next_state = ST_T3;
            end
            ST_T3: begin
                gout       = 1'b1;
                rin_en     = 1'b1;
                done       = 1'b1;
                next_state = ST_T0;
            end
`ifdef PROC_CTRL_ILLEGAL_EN
            ST_HALT: begin
                illegal    = 1'b1;
                next_state = ST_HALT;
            end
`endif
            default: begin
                next_state = ST_T0;
            end
        endcase

        if (clear) begin
            next_state = ST_T0;
            irin       = 1'b0;
            ain        = 1'b0;
            gin        = 1'b0;
            gout       = 1'b0;
            dinout     = 1'b0;
            addsub     = 1'b0;
            done       = 1'b0;
            rin_en     = 1'b0;
            rout_en    = 1'b0;
`ifdef PROC_CTRL_ILLEGAL_EN
            illegal    = 1'b0;
`endif
        end
    end

    dec_onehot #(.W(REG_W)) u_dec_rin (
        .idx    (rx),
        .en     (rin_en),
        .onehot (rin)
    );

    dec_onehot #(.W(REG_W)) u_dec_rout (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (rout)
    );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb/tb_proc_ctrl_fsm.sv - Scoreboard bench for proc_ctrl_fsm (honours PROC_CTRL_ILLEGAL_EN)
module tb_proc_ctrl_fsm;

    localparam logic [6:0] M_NONE = 7'b0000000;
    localparam logic [6:0] M_AIN  = 7'b1000000;
    localparam logic [6:0] M_GIN  = 7'b0100000;
    localparam logic [6:0] M_GOUT = 7'b0010000;
    localparam logic [6:0] M_DIN  = 7'b0001000;
    localparam logic [6:0] M_SUB  = 7'b0000100;
    localparam logic [6:0] M_DONE = 7'b0000010;
    localparam logic [6:0] M_ILL  = 7'b0000001;

    logic       clock;
    logic       clear;
    logic       run;
    logic [8:0] ir_q;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       addsub;
    logic       done;
    logic       ill_obs;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    string       tag_q[$];

    proc_ctrl_fsm dut (
        .clock   (clock),
        .clear   (clear),
        .run     (run),
        .ir_q    (ir_q),
        .irin    (irin),
        .rin     (rin),
        .rout    (rout),
        .ain     (ain),
        .gin     (gin),
        .gout    (gout),
        .dinout  (dinout),
        .addsub  (addsub),
        .done    (done)
`ifdef PROC_CTRL_ILLEGAL_EN
        ,
        .illegal (ill_obs)
`endif
    );

`ifndef PROC_CTRL_ILLEGAL_EN
    assign ill_obs = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] ev(input logic i, input logic [7:0] ri, input logic [7:0] ro,
                                       input logic [6:0] m);
        return {i, ri, ro, m};
    endfunction

    task automatic step(input string tag, input logic c, input logic r, input logic [8:0] ir,
                        input logic [23:0] exp);
        logic [23:0] obs;
        logic [23:0] want;
        string       t;
        clear = c;
        run   = r;
        ir_q  = ir;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clock);
        obs  = {irin, rin, rout, ain, gin, gout, dinout, addsub, done, ill_obs};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, want);
        end
        @(posedge clock);
        #1;
    endtask

    localparam logic [8:0] I_ADD34 = 9'b010_011_100;
    localparam logic [8:0] I_MVI2  = 9'b001_010_000;
    localparam logic [8:0] I_MV51  = 9'b000_101_001;
    localparam logic [8:0] I_SUB07 = 9'b011_000_111;
    localparam logic [8:0] I_ADD12 = 9'b010_001_010;
    localparam logic [8:0] I_MV33  = 9'b000_011_011;
    localparam logic [8:0] I_UND   = 9'b110_000_000;

    initial begin
        clear = 1'b1;
        run   = 1'b0;
        ir_q  = '0;

        step("reset0",     1, 0, 9'd0,    ev(0, 8'h00, 8'h00, M_NONE));
        // add interrupted by clear in T2
        step("add_t0",     0, 1, I_ADD34, ev(1, 8'h00, 8'h00, M_NONE));
        step("add_t1",     0, 0, I_ADD34, ev(0, 8'h00, 8'h08, M_AIN));
        step("clr_in_t2",  1, 1, I_ADD34, ev(0, 8'h00, 8'h00, M_NONE));
        step("clr_hold",   1, 1, I_ADD34, ev(0, 8'h00, 8'h00, M_NONE));
        step("post_clr",   0, 0, I_ADD34, ev(0, 8'h00, 8'h00, M_NONE));
        step("idle_t0",    0, 0, I_ADD34, ev(0, 8'h00, 8'h00, M_NONE));
        // mvi R2,#D
        step("mvi_t0",     0, 1, I_MVI2,  ev(1, 8'h00, 8'h00, M_NONE));
        step("mvi_t1",     0, 0, I_MVI2,  ev(0, 8'h04, 8'h00, M_DIN | M_DONE));
        step("mvi_back",   0, 0, I_MVI2,  ev(0, 8'h00, 8'h00, M_NONE));
        // mv R5,R1
        step("mv_t0",      0, 1, I_MV51,  ev(1, 8'h00, 8'h00, M_NONE));
        step("mv_t1",      0, 0, I_MV51,  ev(0, 8'h20, 8'h02, M_DONE));
        // sub R0,R7 with run held high, then back-to-back add R1,R2
        step("sub_t0",     0, 1, I_SUB07, ev(1, 8'h00, 8'h00, M_NONE));
        step("sub_t1",     0, 1, I_SUB07, ev(0, 8'h00, 8'h01, M_AIN));
        step("sub_t2",     0, 1, I_SUB07, ev(0, 8'h00, 8'h80, M_GIN | M_SUB));
        step("sub_t3",     0, 1, I_SUB07, ev(0, 8'h01, 8'h00, M_GOUT | M_DONE));
        step("b2b_t0",     0, 1, I_ADD12, ev(1, 8'h00, 8'h00, M_NONE));
        step("add12_t1",   0, 1, I_ADD12, ev(0, 8'h00, 8'h02, M_AIN));
        step("add12_t2",   0, 0, I_ADD12, ev(0, 8'h00, 8'h04, M_GIN));
        step("add12_t3",   0, 0, I_ADD12, ev(0, 8'h02, 8'h00, M_GOUT | M_DONE));
        step("add12_wait", 0, 0, I_ADD12, ev(0, 8'h00, 8'h00, M_NONE));
        step("add12_wt2",  0, 0, I_ADD12, ev(0, 8'h00, 8'h00, M_NONE));
        // mv R3,R3
        step("mv33_t0",    0, 1, I_MV33,  ev(1, 8'h00, 8'h00, M_NONE));
        step("mv33_t1",    0, 0, I_MV33,  ev(0, 8'h08, 8'h08, M_DONE));
        // undefined opcode
        step("und_t0",     0, 1, I_UND,   ev(1, 8'h00, 8'h00, M_NONE));
`ifdef PROC_CTRL_ILLEGAL_EN
        step("und_t1",     0, 1, I_UND,   ev(0, 8'h00, 8'h00, M_ILL));
        step("halt_a",     0, 1, I_MVI2,  ev(0, 8'h00, 8'h00, M_ILL));
        step("halt_b",     0, 1, I_MVI2,  ev(0, 8'h00, 8'h00, M_ILL));
`else
        step("und_t1",     0, 1, I_UND,   ev(0, 8'h00, 8'h00, M_DONE));
        step("und_refetch",0, 1, I_UND,   ev(1, 8'h00, 8'h00, M_NONE));
        step("und_t1b",    0, 0, I_UND,   ev(0, 8'h00, 8'h00, M_DONE));
`endif
        step("clr_final",  1, 1, I_MVI2,  ev(0, 8'h00, 8'h00, M_NONE));
        step("post_fin",   0, 0, I_MVI2,  ev(0, 8'h00, 8'h00, M_NONE));
        step("refetch_t0", 0, 1, I_MVI2,  ev(1, 8'h00, 8'h00, M_NONE));
        step("refetch_t1", 0, 0, I_MVI2,  ev(0, 8'h04, 8'h00, M_DIN | M_DONE));

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Multicycle control sequencer for the DE1 simple processor.
- Sits directly upstream of the DFF_reg instances (R0-R7, A, G, IR) and drives their load enables.
- Also drives the bus-source selects and the ALU add/sub control.
- Decodes the 9-bit instruction held in IR and steps through time-steps T0-T3; pulses done on completion.

Parameters:
- REG_W, 3, register-index field width; NREG = 2**REG_W.
- OPC_W, 3, opcode field width.
- IR_W, 9, instruction width; must equal OPC_W + 2*REG_W.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear  input  1  synchronous, active-high reset.
- run  input  1  start request; sampled only in T0.
- ir_q  input  IR_W  Q output of IR register; format III XXX YYY (opcode, Rx, Ry).
- irin  output  1  IR load enable.
- rin  output  NREG  one-hot load enables for R0..R7.
- rout  output  NREG  one-hot bus-drive selects for R0..R7.
- ain  output  1  A register load enable.
- gin  output  1  G register load enable.
- gout  output  1  G drives bus.
- dinout  output  1  external DIN drives bus.
- addsub  output  1  ALU operation: 0 = add, 1 = sub.
- done  output  1  one-cycle instruction-complete pulse.

Behaviour:
- State register: T0, T1, T2, T3 (binary, 2 bits). Outputs are combinational from state and ir_q.
- Reset: while clear = 1, all outputs are forced to 0. The next state is T0 regardless of the current state, including mid-instruction.
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry; 011 sub Rx,Ry; 100-111 undefined.
- T0:
  - irin = run.
  - If run = 1, go to T1 (IR captures DIN on that same edge); otherwise stay in T0.
- T1 (ir_q valid):
  - mv: rout[Y], rin[X], done; go to T0.
  - mvi: dinout, rin[X], done; go to T0.
  - add/sub: rout[X], ain; go to T2.
  - undefined: done only (NOP); go to T0.
- T2: rout[Y], gin, addsub = (opcode == 011); go to T3.
- T3: gout, rin[X], done; go to T0.
- Latency:
  - mv, mvi, NOP: 2 cycles (T0, T1).
  - add, sub: 4 cycles (T0-T3).
- Invariants:
  - At most one of rout/gout/dinout is asserted per cycle (single bus driver).
  - rin is either zero or one-hot.
  - Every output not listed for a state is 0.
- run is ignored outside T0. Deasserting run mid-instruction does not abort the instruction.
- X == Y is legal. Example: mv R3,R3 asserts rout[3] and rin[3] together.
- Back-to-back: run held high re-fetches in the T0 immediately after done. Throughput is 1 instruction per 2 or 4 cycles.

Optional Feature:
- Macro: PROC_CTRL_ILLEGAL_EN.
- Defined:
  - Adds output port illegal (1 bit) and state HALT (state register widens to 3 bits).
  - An undefined opcode in T1 asserts illegal for that cycle, with no done, and moves to HALT.
  - HALT holds all outputs 0 except illegal = 1. It is left only via clear.
- Undefined: undefined opcodes execute as the NOP above; port and state are absent.

Decomposition:
- Package proc_pkg:
  - Opcode constants OPC_MV, OPC_MVI, OPC_ADD, OPC_SUB.
  - State encodings ST_T0..ST_T3, ST_HALT.
  - Field-slice constants for III/XXX/YYY.
- Sub-module dec_onehot (REG_W -> NREG one-hot decoder with enable). Instantiated twice: for Rx-to-rin and for the muxed X/Y index to rout.

Test Plan:
- Reset: clear = 1 for 2 cycles, starting from T2 of an add. Required: all outputs 0 throughout; first cycle after clear drops with run = 0 shows irin = 0 and state T0.
- mvi R2,#0x05: ir = 9'b001_010_000, run = 1. Required: irin = 1 in T0; in T1, dinout = 1, rin = 8'h04, done = 1; back in T0 the next cycle.
- mv R5,R1: ir = 9'b000_101_001. Required: in T1, rout = 8'h02, rin = 8'h20, done = 1; no ain/gin/gout asserted.
- sub R0,R7: ir = 9'b011_000_111. Required:
  - T1: rout = 8'h01, ain = 1.
  - T2: rout = 8'h80, gin = 1, addsub = 1.
  - T3: gout = 1, rin = 8'h01, done = 1.
- Run deasserted in T2 of add R1,R2 (addsub = 0 in T2). Required: instruction completes, done asserted in T3; FSM then waits in T0 with irin = 0.
- Undefined opcode ir = 9'b110_000_000:
  - Macro off: done in T1, no rin/rout asserted.
  - Macro on: illegal = 1 and FSM held in HALT (run = 1 ignored) until clear.
